mem_port_arbiter: RTL and testbench

//   Shares one single-ported memory between the instruction-fetch port (IF) and the

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one single-ported memory between IF and LS ports.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int LS_STREAK = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          ls_req,
  input  logic [AW-1:0] ls_addr,
  input  logic          ls_we,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_done,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_err,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int              SW         = $clog2(LS_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(LS_STREAK);
  localparam logic [15:0]     WD_LAST    = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic            WD_ON      = (TIMEOUT > 0);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_LS = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] streak;
  logic [15:0]   wdog;

  logic          if_elig;
  logic          ls_elig;
  logic          grant_if;
  logic          grant_ls;
  logic          busy;
  logic          timeout_hit;
  logic          finish;
  logic [DW-1:0] rdata_next;

  // A requester still showing its done pulse is masked so it is not re-granted on a stale req.
  assign if_elig     = if_req & ~if_done;
  assign ls_elig     = ls_req & ~ls_done;
  assign grant_ls    = (state == IDLE) & ls_elig & (~if_elig | (streak != STREAK_MAX));
  assign grant_if    = (state == IDLE) & if_elig & ~grant_ls;
  assign busy        = (state != IDLE);
  assign timeout_hit = WD_ON & (wdog == WD_LAST) & ~mem_ready;
  assign finish      = busy & (mem_ready | timeout_hit);
  assign rdata_next  = (mem_ready & ~mem_we) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      streak    <= '0;
      wdog      <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_done   <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
    end else begin
      if_done <= 1'b0;
      if_err  <= 1'b0;
      ls_done <= 1'b0;
      ls_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if || !if_req) begin
            streak <= '0;
          end else if (grant_ls && (streak != STREAK_MAX)) begin
            streak <= streak + 1'b1;
          end
          if (grant_ls) begin
            state     <= BUSY_LS;
            mem_req   <= 1'b1;
            mem_addr  <= ls_addr;
            mem_we    <= ls_we;
            mem_wdata <= ls_wdata;
            wdog      <= '0;
          end else if (grant_if) begin
            state     <= BUSY_IF;
            mem_req   <= 1'b1;
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wdog      <= '0;
          end
        end
        BUSY_IF, BUSY_LS: begin
          if (finish) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state == BUSY_IF) begin
              if_done  <= 1'b1;
              if_err   <= ~mem_ready;
              if_rdata <= rdata_next;
            end else begin
              ls_done  <= 1'b1;
              ls_err   <= ~mem_ready;
              ls_rdata <= rdata_next;
            end
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: randomized requesters and memory against a reference model.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int LS_STREAK = 4;
  localparam int TIMEOUT   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          if_err;
  logic          ls_req = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic          ls_we = 1'b0;
  logic [DW-1:0] ls_wdata = '0;
  logic          ls_done;
  logic [DW-1:0] ls_rdata;
  logic          ls_err;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .LS_STREAK(LS_STREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the memory, how long it has been busy, LS run length.
  int          owner;   // 0 none, 1 IF, 2 LS
  int          age;
  int          ls_run;
  logic        e_mem_req, e_mem_we, e_if_done, e_if_err, e_ls_done, e_ls_err;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_ls_rdata;

  task automatic model_reset();
    owner = 0; age = 0; ls_run = 0;
    e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
    e_if_done = 0; e_if_err = 0; e_if_rdata = '0;
    e_ls_done = 0; e_ls_err = 0; e_ls_rdata = '0;
  endtask

  task automatic model_step();
    bit if_ok, ls_ok, give_if, give_ls, fin, err;
    logic [31:0] data;
    if (owner == 0) begin
      if_ok   = if_req && !e_if_done;
      ls_ok   = ls_req && !e_ls_done;
      give_ls = ls_ok && (!if_ok || ls_run < LS_STREAK);
      give_if = if_ok && !give_ls;
      e_if_done = 0; e_if_err = 0; e_ls_done = 0; e_ls_err = 0;
      if (give_if || !if_req) ls_run = 0;
      else if (give_ls && ls_run < LS_STREAK) ls_run = ls_run + 1;
      if (give_ls) begin
        owner = 2; age = 0; e_mem_req = 1;
        e_mem_addr = ls_addr; e_mem_we = ls_we; e_mem_wdata = ls_wdata;
      end else if (give_if) begin
        owner = 1; age = 0; e_mem_req = 1;
        e_mem_addr = if_addr; e_mem_we = 0; e_mem_wdata = '0;
      end
    end else begin
      fin = 0; err = 0;
      if (mem_ready) fin = 1;
      else if (TIMEOUT > 0 && age == TIMEOUT - 1) begin fin = 1; err = 1; end
      else age = age + 1;
      if (fin) begin
        data = (err || e_mem_we) ? 32'h0 : mem_rdata;
        if (owner == 1) begin e_if_done = 1; e_if_err = err; e_if_rdata = data; end
        else begin e_ls_done = 1; e_ls_err = err; e_ls_rdata = data; end
        owner = 0; e_mem_req = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("mem_req",   mem_req,   e_mem_req);
    check("mem_addr",  mem_addr,  e_mem_addr);
    check("mem_we",    mem_we,    e_mem_we);
    check("mem_wdata", mem_wdata, e_mem_wdata);
    check("if_done",   if_done,   e_if_done);
    check("if_err",    if_err,    e_if_err);
    check("if_rdata",  if_rdata,  e_if_rdata);
    check("ls_done",   ls_done,   e_ls_done);
    check("ls_err",    ls_err,    e_ls_err);
    check("ls_rdata",  ls_rdata,  e_ls_rdata);
  endtask

  // Stimulus knobs and agent state.
  bit          if_on, ls_on, if_fix, ls_fix, rdata_fix;
  int          gap_max, hold_pct, lat_max, lat_fixed;
  int          if_gap, ls_gap, mem_k, mem_lat;
  logic [31:0] if_fix_addr, ls_fix_addr, ls_fix_wdata, fix_rdata;
  logic        ls_fix_we;

  task automatic drive_if();
    if (if_req) begin
      if (e_if_done) begin
        if ($urandom_range(99) >= hold_pct) begin
          if_req = 0;
          if_gap = $urandom_range(gap_max);
        end
      end else if (owner == 1 && !if_fix) begin
        if_addr = $urandom;  // must be ignored while busy
      end
    end else if (if_gap > 0) begin
      if_gap--;
    end else if (if_on) begin
      if_req  = 1;
      if_addr = if_fix ? if_fix_addr : $urandom;
    end
  endtask

  task automatic drive_ls();
    if (ls_req) begin
      if (e_ls_done) begin
        if ($urandom_range(99) >= hold_pct) begin
          ls_req = 0;
          ls_gap = $urandom_range(gap_max);
        end
      end else if (owner == 2 && !ls_fix) begin
        ls_addr = $urandom; ls_we = $urandom_range(1); ls_wdata = $urandom;
      end
    end else if (ls_gap > 0) begin
      ls_gap--;
    end else if (ls_on) begin
      ls_req   = 1;
      ls_addr  = ls_fix ? ls_fix_addr  : $urandom;
      ls_we    = ls_fix ? ls_fix_we    : 1'($urandom_range(1));
      ls_wdata = ls_fix ? ls_fix_wdata : $urandom;
    end
  endtask

  task automatic drive_mem();
    mem_rdata = rdata_fix ? fix_rdata : $urandom;
    if (e_mem_req) begin
      mem_ready = (mem_k == mem_lat);
      mem_k++;
    end else begin
      mem_k     = 0;
      mem_lat   = (lat_fixed >= 0) ? lat_fixed : $urandom_range(lat_max);
      mem_ready = 1'($urandom_range(1));  // ignored outside BUSY
    end
  endtask

  task automatic step();
    drive_if();
    drive_ls();
    drive_mem();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    if_on = 0; ls_on = 0; if_fix = 0; ls_fix = 0; rdata_fix = 0;
    gap_max = 0; hold_pct = 0; lat_max = 0; lat_fixed = -1;
    if_gap = 0; ls_gap = 0; mem_k = 0; mem_lat = 0;
    if_fix_addr = 32'h40; ls_fix_addr = 32'h100; ls_fix_wdata = 32'h5; ls_fix_we = 1;
    fix_rdata = 32'hDEADBEEF;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1;

    // Single IF read from 0x40, zero-wait memory
    if_on = 1; if_fix = 1; rdata_fix = 1; lat_fixed = 0; gap_max = 4;
    run(12);

    // Collision: both rise together, LS store first
    if_on = 0; gap_max = 0;
    run(10);
    if_on = 1; ls_on = 1; ls_fix = 1; if_fix_addr = 32'h0000_2000;
    run(16);

    // Watchdog: never ready, then ready exactly on the last allowed cycle
    if_fix = 0; ls_fix = 0; rdata_fix = 0; gap_max = 2;
    lat_fixed = 20; run(40);
    lat_fixed = TIMEOUT - 1; run(40);

    // Done masking: requesters frequently keep req through their done cycle
    lat_fixed = -1; lat_max = 3; hold_pct = 50; gap_max = 1;
    run(300);

    // Broad random traffic including timeouts
    lat_max = 10; hold_pct = 25; gap_max = 3;
    run(2000);

    // Asynchronous reset while LS owns the memory
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (owner == 2) found = 1;
    end
    check("find_busy_ls", found, 1);
    #2 rst = 0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_ls_done", ls_done, 0);
    if_req = 0; ls_req = 0; if_gap = 0; ls_gap = 0; mem_k = 0; mem_ready = 0;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst = 1;
    run(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
